zion_clr_skid_buf: RTL and testbench
====================================

// Module: zion_clr_skid_buf
// PURPOSE
//   Valid/ready register slice (2-entry skid buffer) with synchronous clear.
//   Receiving end of a registered pipeline stage: accepts data via iVld/oRdy handshake, presents via oVld/iRdy.
//   Sits between pipeline stages to break both the forward (data/valid) and backward (ready) timing paths.
//   Full throughput: 1 beat/cycle sustained.
// PARAMETERS
//   WIDTH_IN   "_"   width of iDat; must equal WIDTH_OUT
//   WIDTH_OUT  "_"   width of oDat
//   INI_DATA   '0    value loaded into both data registers on reset and on clear
// PORTS
//   clk   in   1          clock, rising edge
//   rst   in   1          asynchronous reset, active low
//   iClr  in   1          synchronous clear/flush, active high
//   iVld  in   1          upstream data valid
//   oRdy  out  1          ready to upstream; registered
//   iDat  in   WIDTH_IN   upstream data
//   oVld  out  1          downstream data valid; registered
//   iRdy  in   1          downstream ready
//   oDat  out  WIDTH_OUT  downstream data; registered, driven directly from the main register
// BEHAVIOUR
//   - Reset (rst=0, async): oVld=0, oRdy=1, oDat=INI_DATA, skid reg=INI_DATA, state EMPTY.
//   - Beat transfer: upstream on iVld&oRdy; downstream on oVld&iRdy.
//   - State machine (registered, one-hot or enum):
//       EMPTY (main empty, skid empty): oVld=0, oRdy=1. in-beat -> main, go BUSY.
//       BUSY  (main full,  skid empty): oVld=1, oRdy=1.
//             in&out -> main<=iDat, stay BUSY; in only -> skid<=iDat, go FULL;
//             out only -> go EMPTY; neither -> hold.
//       FULL  (main full,  skid full):  oVld=1, oRdy=0.
//             out -> main<=skid, go BUSY; else hold.
//   - oRdy = (state != FULL), registered with state; no combinational iRdy->oRdy or iVld->oVld path.
//   - Latency: beat accepted at edge N is on oDat/oVld after edge N (1 cycle) when EMPTY.
//   - Ordering: strict FIFO; no drop, no duplication. Skid entry always older than any new input.
//   - oDat stable while oVld=1 and iRdy=0 (hold until accepted).
//   - iVld while oRdy=0: ignored (not a transfer); upstream must hold per protocol.
//   - iClr=1 (priority over all handshakes): next state EMPTY, oVld=0, oRdy=1, both data regs<=INI_DATA;
//     any beat offered/accepted in the clear cycle is discarded; a downstream beat with iRdy=1 that cycle still counts as consumed.
//   - Reset asserted mid-operation: immediate async return to reset values; in-flight beats lost.
//   - Width rule: no truncation/extension; WIDTH_IN != WIDTH_OUT -> $error at elaboration
//     ($finish when CHECK_ERR_EXIT defined).
// STRUCTURE
//   - Package zion_skid_pkg: typedef enum logic[1:0] {SKID_EMPTY, SKID_BUSY, SKID_FULL} skid_state_e.
//   - One sub-module natural: zion_clr_en_reg (async-reset, clear, enable data register, INI_DATA on reset/clear),
//     instantiated twice (main, skid); enables/muxes derived from state in this module.
//   - Provide a wrapper macro in the codebase style binding widths via $bits of the connected signals.
// TESTING
//   - Reset: rst low mid-traffic with WIDTH=8, INI_DATA=8'hA5 -> oVld=0, oRdy=1, oDat=8'hA5 immediately (async).
//   - Streaming: iRdy=1, iVld=1, iDat=1,2,3..16 on consecutive cycles -> oDat=1..16, one per cycle, 1-cycle latency, oRdy never 0.
//   - Backpressure: iRdy=0, send 8'h11,8'h22 -> oRdy=0 after 2nd beat, oDat=8'h11 held; iRdy=1 -> 11,22 in order, oRdy=1.
//   - Clear: FULL with 8'h33,8'h44, pulse iClr with iVld=1 iDat=8'h55 -> next cycle oVld=0, oRdy=1, oDat=8'hA5; 33/44/55 never emitted.
//   - Random iVld/iRdy (10k cycles, scoreboard) -> in-order, lossless, oDat stable while oVld&!iRdy.
//   - Param check: WIDTH_IN=8, WIDTH_OUT=9 -> elaboration $error.

Source files
------------

// File: rtl/zion_skid_pkg.sv
// zion_skid_pkg: shared state encoding and instantiation macro for the clearable skid buffer
package zion_skid_pkg;
    typedef enum logic [1:0] {SKID_EMPTY, SKID_BUSY, SKID_FULL} skid_state_e;
endpackage

// Widths come from the connected signals so callers cannot mismatch them by hand
`define ZION_CLR_SKID_BUF(name_, ini_, clk_, rst_, clr_, iVld_, oRdy_, iDat_, oVld_, iRdy_, oDat_) \
    zion_clr_skid_buf #(.WIDTH_IN($bits(iDat_)), .WIDTH_OUT($bits(oDat_)), .INI_DATA(ini_)) name_ ( \
        .clk(clk_), .rst(rst_), .iClr(clr_), .iVld(iVld_), .oRdy(oRdy_), .iDat(iDat_), \
        .oVld(oVld_), .iRdy(iRdy_), .oDat(oDat_));

// File: rtl/zion_clr_en_reg.sv
// zion_clr_en_reg: async-reset data register with synchronous clear and load enable
module zion_clr_en_reg #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iClr,
    input  logic             iEn,
    input  logic [WIDTH-1:0] iDat,
    output logic [WIDTH-1:0] oDat
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) oDat <= INI_DATA;
        else if (iClr) oDat <= INI_DATA;
        else if (iEn) oDat <= iDat;
endmodule

// File: rtl/zion_clr_skid_buf.sv
// zion_clr_skid_buf: 2-entry valid/ready register slice with synchronous clear
// Both handshake outputs come straight from flops, breaking forward and backward timing paths.
module zion_clr_skid_buf
    import zion_skid_pkg::*;
#(
    parameter int WIDTH_IN = 8,
    parameter int WIDTH_OUT = 8,
    parameter logic [WIDTH_OUT-1:0] INI_DATA = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iClr,
    input  logic                 iVld,
    output logic                 oRdy,
    input  logic [WIDTH_IN-1:0]  iDat,
    output logic                 oVld,
    input  logic                 iRdy,
    output logic [WIDTH_OUT-1:0] oDat
);
    generate
        if (WIDTH_IN != WIDTH_OUT) begin : gWidthErr
`ifdef CHECK_ERR_EXIT
            $fatal(1, "zion_clr_skid_buf: WIDTH_IN (%0d) != WIDTH_OUT (%0d)", WIDTH_IN, WIDTH_OUT);
`else
            $error("zion_clr_skid_buf: WIDTH_IN (%0d) != WIDTH_OUT (%0d)", WIDTH_IN, WIDTH_OUT);
`endif
        end
    endgenerate

    skid_state_e state, nxtState;
    logic inAcc, outAcc, mainEn, skidEn;
    logic [WIDTH_OUT-1:0] skidDat, mainNxt;

    assign inAcc = iVld & oRdy;
    assign outAcc = oVld & iRdy;

    // Main refills from the skid entry when draining FULL, otherwise from upstream
    assign mainEn = (state == SKID_EMPTY && inAcc) || (state == SKID_BUSY && inAcc && outAcc) ||
                    (state == SKID_FULL && outAcc);
    assign mainNxt = (state == SKID_FULL) ? skidDat : iDat;
    assign skidEn = (state == SKID_BUSY) && inAcc && !outAcc;

    always_comb begin
        nxtState = iClr ? SKID_EMPTY :
                   (state == SKID_EMPTY) ? (inAcc ? SKID_BUSY : SKID_EMPTY) :
                   (state == SKID_BUSY) ? ((inAcc && !outAcc) ? SKID_FULL :
                                           (!inAcc && outAcc) ? SKID_EMPTY : SKID_BUSY) :
                   (outAcc ? SKID_BUSY : SKID_FULL);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= SKID_EMPTY;
            oVld <= 1'b0;
            oRdy <= 1'b1;
        end else begin
            state <= nxtState;
            oVld <= nxtState != SKID_EMPTY;
            oRdy <= nxtState != SKID_FULL;
        end

    zion_clr_en_reg #(.WIDTH(WIDTH_OUT), .INI_DATA(INI_DATA)) uMain (
        .clk(clk), .rst(rst), .iClr(iClr), .iEn(mainEn), .iDat(mainNxt), .oDat(oDat)
    );

    zion_clr_en_reg #(.WIDTH(WIDTH_OUT), .INI_DATA(INI_DATA)) uSkid (
        .clk(clk), .rst(rst), .iClr(iClr), .iEn(skidEn), .iDat(iDat), .oDat(skidDat)
    );
endmodule

// File: tb/tb_zion_clr_skid_buf.sv
// tb_zion_clr_skid_buf: directed vector table, corner sequences and a random scoreboard run
module tb_zion_clr_skid_buf;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic iClr = 1'b0;
    logic iVld = 1'b0;
    logic iRdy = 1'b0;
    logic [7:0] iDat = 8'h00;
    logic oVld, oRdy;
    logic [7:0] oDat;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    zion_clr_skid_buf #(.WIDTH_IN(8), .WIDTH_OUT(8), .INI_DATA(8'hA5)) dut (
        .clk(clk), .rst(rst), .iClr(iClr), .iVld(iVld), .oRdy(oRdy), .iDat(iDat),
        .oVld(oVld), .iRdy(iRdy), .oDat(oDat)
    );

    typedef struct {
        logic clr;
        logic vld;
        logic [7:0] dat;
        logic rdy;
        logic eVld;
        logic eRdy;
        logic [7:0] eDat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[14];
        logic [7:0] q[$];
        logic [7:0] exp;
        logic [7:0] heldDat;
        logic held;
        logic lastInAcc;
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[1]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11};
        vecs[2]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'h11};
        vecs[3]  = '{1'b0, 1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 8'h11};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22};
        vecs[6]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h33};
        vecs[7]  = '{1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 8'h33};
        vecs[8]  = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'hA5};
        vecs[9]  = '{1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 8'h66};
        vecs[10] = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'h77};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h77};
        vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5};

        #12;
        chk("reset.vld", oVld, 0);
        chk("reset.rdy", oRdy, 1);
        chk("reset.dat", oDat, 8'hA5);
        @(negedge clk) rst = 1'b1;

        // Backpressure, ignored beat while full, drain, clear and pass-through
        foreach (vecs[i]) begin
            @(negedge clk);
            iClr = vecs[i].clr;
            iVld = vecs[i].vld;
            iDat = vecs[i].dat;
            iRdy = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.vld", i), oVld, vecs[i].eVld);
            chk($sformatf("vec%0d.rdy", i), oRdy, vecs[i].eRdy);
            chk($sformatf("vec%0d.dat", i), oDat, vecs[i].eDat);
        end

        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            iClr = 1'b0;
            iVld = 1'b1;
            iDat = 8'(i);
            iRdy = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d.dat", i), oDat, i);
            chk($sformatf("stream%0d.vld", i), oVld, 1);
            chk($sformatf("stream%0d.rdy", i), oRdy, 1);
        end
        @(negedge clk) iVld = 1'b0;
        @(posedge clk);
        #1;
        chk("stream.end.vld", oVld, 0);

        // Fill to FULL then assert reset between edges
        @(negedge clk);
        iVld = 1'b1;
        iDat = 8'hC1;
        iRdy = 1'b0;
        @(negedge clk) iDat = 8'hC2;
        @(negedge clk) iVld = 1'b0;
        chk("prerst.rdy", oRdy, 0);
        #2 rst = 1'b0;
        #1;
        chk("asyncrst.vld", oVld, 0);
        chk("asyncrst.rdy", oRdy, 1);
        chk("asyncrst.dat", oDat, 8'hA5);
        @(negedge clk) rst = 1'b1;
        iRdy = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst.vld", oVld, 0);

        held = 1'b0;
        heldDat = 8'h00;
        lastInAcc = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (held) begin
                chk("stable.vld", oVld, 1);
                chk("stable.dat", oDat, heldDat);
            end
            if (!(iVld && !lastInAcc)) begin
                iVld = 1'($urandom_range(0, 1));
                iDat = 8'($urandom);
            end
            iRdy = 1'($urandom_range(0, 1));
            if (oVld && iRdy) begin
                exp = (q.size() > 0) ? q.pop_front() : 8'hXX;
                chk("sb.dat", oDat, exp);
            end
            lastInAcc = iVld && oRdy;
            if (lastInAcc) q.push_back(iDat);
            held = oVld && !iRdy;
            heldDat = oDat;
        end
        @(negedge clk);
        iVld = 1'b0;
        iRdy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (oVld) begin
                exp = (q.size() > 0) ? q.pop_front() : 8'hXX;
                chk("drain.dat", oDat, exp);
            end
            @(negedge clk);
        end
        chk("drain.left", q.size(), 0);
        chk("drain.vld", oVld, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
